dm_access_unit: RTL
===================

# dm_access_unit

Memory-stage initiator for the data memory. Accepts load/store requests from the EX/MEM pipeline register and drives the data memory's read/write port. All memory-facing controls come from registers, so the write strobe is a clean one-cycle pulse. Adds byte/halfword loads with sign/zero extension, sub-word stores by read-modify-write, misalignment detection and a pipeline stall.

## Interface
- ADDR_W, 7, byte-address width; matches the data memory's address width (32 words).
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  zero-extend sub-word loads (LBU/LHU); ignored for stores and words.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; sub-word data is right-justified.
- req_ready  out  1  request accepted when req_valid & req_ready; low means stall the pipeline.
- resp_valid  out  1  one-cycle completion pulse, one per accepted request.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_misalign  out  1  with resp_valid: request was misaligned or illegal and was not performed.
- dm_R_addr, dm_W_addr  out  ADDR_W  memory read/write byte addresses; the memory ignores bits [1:0].
- dm_MemRead, dm_MemWrite  out  1  memory strobes.
- dm_W_data  out  32  memory write word.
- dm_R_data  in  32  combinational memory read word.

## Operation
- Byte order is big-endian. Byte offset 0 maps to bits [31:24]. Half offset 0 maps to [31:16].
- Alignment:
  - Half requires addr[0]=0.
  - Word requires addr[1:0]=00.
  - Size 11 is always an error.
  - An error makes no memory access: resp_misalign=1 and resp_rdata=0.
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR, ERR.
- Transitions on an accepted request (legal stores split by size):
  - Load goes to LOAD.
  - Word store goes to STORE.
  - Byte or half store goes to RMW_RD.
  - Error goes to ERR.
- Exit transitions:
  - LOAD, STORE, ERR and RMW_WR return to IDLE, or go directly to the next state if a new request is accepted that cycle.
  - RMW_RD always goes to RMW_WR.
- req_ready = 0 only in RMW_RD; high in every other state.
- LOAD: dm_MemRead=1 and dm_R_addr=registered address. resp_rdata = extracted lane from dm_R_data, sign- or zero-extended, presented combinationally in the same cycle.
- STORE: dm_MemWrite=1, dm_W_addr=addr, dm_W_data=req_wdata (all registered).
- RMW_RD: dm_MemRead=1. The word read back, with the new byte/half inserted into its lane, is registered into dm_W_data.
- RMW_WR: dm_MemWrite=1 for exactly this cycle.
- Strobes are 0 in every state not listed above. dm_MemWrite is never asserted for an error or a load.
- resp_valid is high in LOAD, STORE, ERR and RMW_WR, and low in IDLE and RMW_RD.
- Load directly after a store: the load's LOAD cycle follows the store's write cycle, so it returns the new data.

## Timing
- Request accepted at edge N.
- Load, word store, error: resp_valid in cycle N+1; throughput 1/cycle.
- Sub-word store: RMW_RD in cycle N+1 (req_ready=0), RMW_WR and resp_valid in N+2; throughput 1 per 2 cycles.
- Reset values: state IDLE, all dm_* outputs 0, resp_valid=0, resp_rdata=0, resp_misalign=0, req_ready=1.
- Reset during RMW_RD or RMW_WR aborts the access. dm_MemWrite is 0 from the cycle after the reset edge, and no response is issued.
- req_valid=0 in an exit state leads to IDLE with all strobes 0.

## Structure
- Package mips_mem_pkg holds:
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD/SIZE_ILL constants.
  - The state enum.
  - The ADDR_W default.
- One combinational sub-module, dm_lane_unit:
  - Extract-and-extend, from (word, offset, size, unsigned) to a 32-bit result.
  - Insert, from (word, offset, size, data) to the merged word.

## Test plan
- Reset, then word store 0xDEADBEEF at 0x08 → dm_MemWrite high exactly one cycle, dm_W_addr=0x08. Word load at 0x08 next cycle → resp_rdata=0xDEADBEEF at N+1.
- Memory word 0x11223344 at 0x04. LB at 0x07 → 0x00000044. LH at 0x04 → 0x00001122. Memory word 0x80FF0000, LB at 0x04 → 0xFFFFFF80; LBU → 0x00000080.
- SB 0xAA at 0x05 over 0x11223344 → req_ready low one cycle, dm_W_data=0x11AA3344 in cycle N+2. A following LW returns 0x11AA3344.
- LW at 0x06, LH at 0x03, and size 11 → resp_misalign=1, resp_rdata=0, dm_MemWrite and dm_MemRead stay 0.
- Back-to-back SW, LW, SB, LW with req_valid held → responses at cycles 1, 2, 4, 5. The final load sees the merged byte.
- rst asserted in the RMW_RD cycle of an SB → no dm_MemWrite pulse, memory unchanged, no resp_valid.

Source files
------------

// File: rtl/dm_access_unit_pkg.sv
// Shared types and constants for the data-memory access unit.
package mips_mem_pkg;

    // Default byte-address width: 32 words of data memory.
    localparam int DM_ADDR_W = 7;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STORE,
        RMW_RD,
        RMW_WR,
        ERR
    } dm_state_t;

    // Operation fields kept for the duration of a multi-cycle access.
    typedef struct packed {
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
    } dm_op_t;

    // Misaligned or illegal-size access: such a request never touches memory.
    function automatic logic access_err(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SIZE_BYTE: access_err = 1'b0;
            SIZE_HALF: access_err = off[0];
            SIZE_WORD: access_err = |off;
            default:   access_err = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dm_access_unit_if.sv
// Request/response and data-memory port bundle of the access unit.
interface dm_access_unit_if
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = DM_ADDR_W
);
    logic              req_valid;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              req_ready;

    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_misalign;

    logic [ADDR_W-1:0] dm_R_addr;
    logic [ADDR_W-1:0] dm_W_addr;
    logic              dm_MemRead;
    logic              dm_MemWrite;
    logic [31:0]       dm_W_data;
    logic [31:0]       dm_R_data;

    // Access unit side.
    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_misalign,
        output dm_R_addr, dm_W_addr, dm_MemRead, dm_MemWrite, dm_W_data,
        input  dm_R_data
    );

    // Pipeline plus memory side.
    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_misalign,
        input  dm_R_addr, dm_W_addr, dm_MemRead, dm_MemWrite, dm_W_data,
        output dm_R_data
    );

endinterface

// File: rtl/dm_access_unit_lane.sv
// Big-endian lane handling: extract/extend for loads, insert for sub-word stores.
module dm_lane_unit
    import mips_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] data,
    output logic [31:0] ext_data,
    output logic [31:0] merged
);
    // Offset 0 is the most significant lane, so the shift is (3 - off) bytes.
    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [31:0] byte_word;
    logic [31:0] half_word;

    assign byte_sh   = {~offset, 3'b000};
    assign half_sh   = {~offset[1], 4'b0000};
    assign byte_word = word >> byte_sh;
    assign half_word = word >> half_sh;

    // Select the addressed lane and sign/zero extend it.
    always_comb begin
        ext_data = word;
        case (size)
            SIZE_BYTE: ext_data = {{24{~uns & byte_word[7]}}, byte_word[7:0]};
            SIZE_HALF: ext_data = {{16{~uns & half_word[15]}}, half_word[15:0]};
            default:   ext_data = word;
        endcase
    end

    // Replace the addressed lane of the read word with the store data.
    always_comb begin
        merged = data;
        case (size)
            SIZE_BYTE: merged = (word & ~(32'h0000_00FF << byte_sh)) |
                                ({24'b0, data[7:0]} << byte_sh);
            SIZE_HALF: merged = (word & ~(32'h0000_FFFF << half_sh)) |
                                ({16'b0, data[15:0]} << half_sh);
            default:   merged = data;
        endcase
    end

endmodule

// File: rtl/dm_access_unit.sv
// Memory-stage initiator: loads, word stores, sub-word read-modify-write stores.
module dm_access_unit
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = DM_ADDR_W
)
(
    input  logic             clk,
    input  logic             rst,
    dm_access_unit_if.slave  bus
);
    dm_state_t         state;
    dm_op_t            op_q;
    logic              ready_q;
    logic              rvalid_q;
    logic              mis_q;
    logic              rd_q;
    logic              wr_q;
    logic [ADDR_W-1:0] raddr_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [31:0]       wdata_q;

    logic              accept;
    logic              err_in;
    logic [31:0]       ext_data;
    logic [31:0]       merged;

    assign accept = bus.req_valid & ready_q;
    assign err_in = access_err(bus.req_size, bus.req_addr[1:0]);

    // Lane logic always works on the registered access (LOAD or RMW_RD).
    dm_lane_unit u_lane (
        .word     (bus.dm_R_data),
        .offset   (raddr_q[1:0]),
        .size     (op_q.size),
        .uns      (op_q.uns),
        .data     (op_q.wdata),
        .ext_data (ext_data),
        .merged   (merged)
    );

    // Access FSM; every memory-facing control and response flag is a register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= '0;
            ready_q  <= 1'b1;
            rvalid_q <= 1'b0;
            mis_q    <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            raddr_q  <= '0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            ready_q  <= 1'b1;
            rvalid_q <= 1'b0;
            mis_q    <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            if (state == RMW_RD) begin
                // The read word is on dm_R_data now; write it back merged.
                state    <= RMW_WR;
                wr_q     <= 1'b1;
                wdata_q  <= merged;
                rvalid_q <= 1'b1;
            end else if (accept) begin
                op_q <= '{size: bus.req_size, uns: bus.req_unsigned, wdata: bus.req_wdata};
                if (err_in) begin
                    state    <= ERR;
                    rvalid_q <= 1'b1;
                    mis_q    <= 1'b1;
                end else if (!bus.req_write) begin
                    state    <= LOAD;
                    rd_q     <= 1'b1;
                    raddr_q  <= bus.req_addr;
                    rvalid_q <= 1'b1;
                end else if (bus.req_size == SIZE_WORD) begin
                    state    <= STORE;
                    wr_q     <= 1'b1;
                    waddr_q  <= bus.req_addr;
                    wdata_q  <= bus.req_wdata;
                    rvalid_q <= 1'b1;
                end else begin
                    state   <= RMW_RD;
                    rd_q    <= 1'b1;
                    raddr_q <= bus.req_addr;
                    waddr_q <= bus.req_addr;
                    ready_q <= 1'b0;
                end
            end else begin
                state <= IDLE;
            end
        end
    end

    assign bus.req_ready     = ready_q;
    assign bus.resp_valid    = rvalid_q;
    assign bus.resp_misalign = mis_q;
    // Load data is combinational from the memory in the LOAD cycle.
    assign bus.resp_rdata    = (state == LOAD) ? ext_data : 32'h0;
    assign bus.dm_MemRead    = rd_q;
    assign bus.dm_MemWrite   = wr_q;
    assign bus.dm_R_addr     = raddr_q;
    assign bus.dm_W_addr     = waddr_q;
    assign bus.dm_W_data     = wdata_q;

endmodule
